// File: rtl/mem_arb_pkg.sv
// Shared definitions for the byte-serial memory arbiter: FSM encodings,
// access size codes, grant IDs and small byte-lane helpers.
package mem_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_TAIL = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic GNT_IC  = 1'b0;
  localparam logic GNT_LSB = 1'b1;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  typedef struct packed {
    logic        gnt;
    logic        we;
    logic        sgn;
    logic [1:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  localparam xfer_t XFER_NONE = '{gnt: 1'b0, we: 1'b0, sgn: 1'b0, size: 2'b00, wdata: 32'h0000_0000};

  // Index of the final byte lane for an access size; size 11 behaves as a word.
  function automatic logic [1:0] last_lane(input logic [1:0] size);
    case (size)
      SZ_B:    last_lane = 2'd0;
      SZ_H:    last_lane = 2'd1;
      default: last_lane = 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-port bundle for mem_arbiter; the slave modport is
// the arbiter's view, the master modport the requesters' and RAM's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [31:0]       ic_data;
  logic              lsb_req;
  logic              lsb_we;
  logic [1:0]        lsb_size;
  logic              lsb_signed;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  ic_req, ic_addr, lsb_req, lsb_we, lsb_size, lsb_signed, lsb_addr, lsb_wdata,
    input  mem_din, io_buffer_full,
    output ic_done, ic_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ic_req, ic_addr, lsb_req, lsb_we, lsb_size, lsb_signed, lsb_addr, lsb_wdata,
    output mem_din, io_buffer_full,
    input  ic_done, ic_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/byte_assembler.sv
// Collects read bytes into little-endian lanes and extends the result by size.
// The result already includes the byte being captured this cycle.
module byte_assembler
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        cap_en,
  input  logic [1:0]  cap_lane,
  input  logic [7:0]  din,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [1:0]  last_lane_o,
  output logic [31:0] result
);
  logic [31:0] lanes_q;
  logic [31:0] lanes_d;

  // Merge the incoming byte into its lane.
  always_comb begin
    lanes_d = lanes_q;
    if (clear) begin
      lanes_d = 32'h0000_0000;
    end else if (cap_en) begin
      case (cap_lane)
        2'd0:    lanes_d[7:0]   = din;
        2'd1:    lanes_d[15:8]  = din;
        2'd2:    lanes_d[23:16] = din;
        default: lanes_d[31:24] = din;
      endcase
    end else begin
      lanes_d = lanes_q;
    end
  end

  // Lane capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= 32'h0000_0000;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  // Zero/sign extension of sub-word loads.
  always_comb begin
    case (size)
      SZ_B:    result = {{24{sgn & lanes_d[7]}}, lanes_d[7:0]};
      SZ_H:    result = {{16{sgn & lanes_d[15]}}, lanes_d[15:0]};
      default: result = lanes_d;
    endcase
  end

  assign last_lane_o = last_lane(size);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IC fetches and LSB loads/stores onto a byte-wide RAM port.
// Optional MEM_ARB_IO_STALL_EN: stores into the IO window wait while io_buffer_full.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  mem_arbiter_if.slave bus,
  output logic         busy
);
  logic [2:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  xfer_t             xfer_q, xfer_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              ic_done_q, ic_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [31:0]       ic_data_q, ic_data_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;
  logic              busy_q, busy_d;

  logic              grant_s;
  logic              asm_clear_s;
  logic              cap_en_s;
  logic [1:0]        cap_lane_s;
  logic [1:0]        last_lane_s;
  logic [31:0]       asm_result_s;
  logic              io_window_s;
  logic              stall_s;

  assign io_window_s = (base_q >= IO_BASE);

`ifdef MEM_ARB_IO_STALL_EN
  assign stall_s = (state_q == ST_WR) && io_window_s && bus.io_buffer_full;
`else
  logic unused_io_s;
  assign stall_s     = 1'b0;
  assign unused_io_s = io_window_s ^ bus.io_buffer_full;
`endif

  byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (asm_clear_s),
    .cap_en      (cap_en_s),
    .cap_lane    (cap_lane_s),
    .din         (bus.mem_din),
    .size        (xfer_q.size),
    .sgn         (xfer_q.sgn),
    .last_lane_o (last_lane_s),
    .result      (asm_result_s)
  );

  // Round-robin tie break against the previous winner.
  always_comb begin
    if (bus.ic_req && bus.lsb_req) begin
      grant_s = ~last_grant_q;
    end else if (bus.ic_req) begin
      grant_s = GNT_IC;
    end else begin
      grant_s = GNT_LSB;
    end
  end

  // RAM data returns one cycle after its address, so lane k-1 lands while k is issued.
  always_comb begin
    if (state_q == ST_RD_TAIL) begin
      cap_en_s   = 1'b1;
      cap_lane_s = last_lane_s;
    end else if ((state_q == ST_RD) && (k_q != 2'd0)) begin
      cap_en_s   = 1'b1;
      cap_lane_s = k_q - 2'd1;
    end else begin
      cap_en_s   = 1'b0;
      cap_lane_s = 2'd0;
    end
  end

  // Next-state, next-address and response logic.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    base_d       = base_q;
    xfer_d       = xfer_q;
    last_grant_d = last_grant_q;
    mem_a_d      = {ADDR_W{1'b0}};
    mem_wr_d     = 1'b0;
    mem_dout_d   = 8'h00;
    ic_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    ic_data_d    = ic_data_q;
    lsb_rdata_d  = lsb_rdata_q;
    asm_clear_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && (bus.ic_req || bus.lsb_req)) begin
          asm_clear_s  = 1'b1;
          k_d          = 2'd0;
          last_grant_d = grant_s;
          if (grant_s == GNT_IC) begin
            base_d  = bus.ic_addr;
            xfer_d  = '{gnt: GNT_IC, we: 1'b0, sgn: 1'b0, size: SZ_W, wdata: 32'h0000_0000};
            mem_a_d = bus.ic_addr;
            state_d = ST_RD;
          end else begin
            base_d  = bus.lsb_addr;
            xfer_d  = '{gnt: GNT_LSB, we: bus.lsb_we, sgn: bus.lsb_signed,
                        size: bus.lsb_size, wdata: bus.lsb_wdata};
            mem_a_d = bus.lsb_addr;
            if (bus.lsb_we) begin
              state_d    = ST_WR;
              mem_wr_d   = 1'b1;
              mem_dout_d = bus.lsb_wdata[7:0];
            end else begin
              state_d = ST_RD;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (k_q == last_lane_s) begin
          state_d = ST_RD_TAIL;
        end else begin
          k_d     = k_q + 2'd1;
          mem_a_d = base_q + ADDR_W'(k_q + 2'd1);
        end
      end
      ST_RD_TAIL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (xfer_q.gnt == GNT_IC) begin
            ic_done_d = 1'b1;
            ic_data_d = asm_result_s;
          end else begin
            lsb_done_d  = 1'b1;
            lsb_rdata_d = asm_result_s;
          end
        end
      end
      ST_WR: begin
        // Stores are never aborted by flush.
        if (stall_s) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = mem_a_q;
          mem_dout_d = mem_dout_q;
        end else if (k_q == last_lane_s) begin
          state_d    = ST_DONE;
          lsb_done_d = 1'b1;
        end else begin
          k_d        = k_q + 2'd1;
          mem_wr_d   = 1'b1;
          mem_a_d    = base_q + ADDR_W'(k_q + 2'd1);
          mem_dout_d = byte_lane(xfer_q.wdata, k_q + 2'd1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      base_q       <= {ADDR_W{1'b0}};
      xfer_q       <= XFER_NONE;
      last_grant_q <= GNT_LSB;
      mem_a_q      <= {ADDR_W{1'b0}};
      mem_wr_q     <= 1'b0;
      mem_dout_q   <= 8'h00;
      ic_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      ic_data_q    <= 32'h0000_0000;
      lsb_rdata_q  <= 32'h0000_0000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      base_q       <= base_d;
      xfer_q       <= xfer_d;
      last_grant_q <= last_grant_d;
      mem_a_q      <= mem_a_d;
      mem_wr_q     <= mem_wr_d;
      mem_dout_q   <= mem_dout_d;
      ic_done_q    <= ic_done_d;
      lsb_done_q   <= lsb_done_d;
      ic_data_q    <= ic_data_d;
      lsb_rdata_q  <= lsb_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wr    = mem_wr_q & ~stall_s;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.ic_data   = ic_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model
// (grant order, byte timeline offsets, RAM image, load extension).
module tb_mem_arbiter;
  localparam logic [31:0] IO_B = 32'h0003_0000;
`ifdef MEM_ARB_IO_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          anc_v;
    logic [31:0] anc;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_BASE(IO_B)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] env_ram [logic [31:0]];
  logic [7:0] ref_ram [logic [31:0]];
  req_t ic_q[$];
  req_t lsb_q[$];

  // requester state
  bit ic_pend, lsb_pend;
  int ic_gap, lsb_gap;
  req_t ic_r, lsb_r;

  // reference model state
  bit          m_act, m_who, m_we, m_sgn, m_wdone, m_last;
  logic [31:0] m_addr, m_wdata, m_rdata, m_ic_h, m_lsb_h;
  int          m_n, m_t, m_w;
  bit          stall_now;
  bit          fl_ic_once, fl_st_once;
  logic [7:0]  next_din;
  bit          next_rst, next_flush;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_ram.exists(a) ? env_ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned s = $urandom_range(0, 9);
    if (s < 6) return 32'h0000_0400 + 32'($urandom_range(0, 63));
    else if (s < 8) return IO_B - 32'd2 + 32'($urandom_range(0, 5));
    else return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
  endfunction

  task automatic new_ic();
    if (ic_q.size() > 0) ic_r = ic_q.pop_front();
    else ic_r = '{we: 1'b0, size: 2'b10, sgn: 1'b0, addr: rand_addr(), wdata: 32'h0, anc_v: 1'b0, anc: 32'h0};
    ic_pend = 1'b1;
  endtask

  task automatic new_lsb();
    if (lsb_q.size() > 0) lsb_r = lsb_q.pop_front();
    else lsb_r = '{we: 1'($urandom_range(0, 1)), size: 2'($urandom_range(0, 3)),
                   sgn: 1'($urandom_range(0, 1)), addr: rand_addr(), wdata: $urandom(),
                   anc_v: 1'b0, anc: 32'h0};
    lsb_pend = 1'b1;
  endtask

  task automatic drive_inputs();
    rst               = next_rst;
    flush             = next_flush;
    bus.mem_din       = next_din;
    bus.ic_req        = ic_pend && (ic_gap == 0);
    bus.ic_addr       = ic_r.addr;
    bus.lsb_req       = lsb_pend && (lsb_gap == 0);
    bus.lsb_we        = lsb_r.we;
    bus.lsb_size      = lsb_r.size;
    bus.lsb_signed    = lsb_r.sgn;
    bus.lsb_addr      = lsb_r.addr;
    bus.lsb_wdata     = lsb_r.wdata;
    bus.io_buffer_full = ($urandom_range(0, 9) < 4);
  endtask

  // Expected outputs for the current cycle, compared against the DUT.
  task automatic model_check();
    logic [31:0] exp_a = 32'h0;
    bit exp_wr = 1'b0, exp_icd = 1'b0, exp_lsbd = 1'b0;
    stall_now = 1'b0;
    if (m_act) begin
      if (!m_we) begin
        if (m_t <= m_n) exp_a = m_addr + 32'(m_t - 1);
        if (m_t == m_n + 2) begin
          if (m_who == 1'b0) begin exp_icd = 1'b1; m_ic_h = m_rdata; end
          else begin exp_lsbd = 1'b1; m_lsb_h = m_rdata; end
        end
      end else if (!m_wdone) begin
        stall_now = STALL_EN && (m_addr >= IO_B) && bus.io_buffer_full;
        exp_a  = m_addr + 32'(m_w);
        exp_wr = !stall_now;
      end else begin
        exp_lsbd = 1'b1;
      end
    end
    check_val("mem_a", bus.mem_a, exp_a);
    check_val("mem_wr", 32'(bus.mem_wr), 32'(exp_wr));
    if (exp_wr) check_val("mem_dout", 32'(bus.mem_dout), 32'(m_wdata[8*m_w +: 8]));
    check_val("ic_done", 32'(bus.ic_done), 32'(exp_icd));
    check_val("lsb_done", 32'(bus.lsb_done), 32'(exp_lsbd));
    check_val("busy", 32'(busy), 32'(m_act));
    check_val("ic_data", bus.ic_data, m_ic_h);
    check_val("lsb_rdata", bus.lsb_rdata, m_lsb_h);
    if (exp_icd && ic_r.anc_v) check_val("ic_fetch_word", bus.ic_data, ic_r.anc);
    if (exp_lsbd && lsb_r.anc_v && !m_we) check_val("lsb_load_ext", bus.lsb_rdata, lsb_r.anc);
    if (exp_lsbd && lsb_r.anc_v && m_we) begin
      check_val("store_byte0", 32'(env_rd(lsb_r.addr)), 32'(lsb_r.anc[7:0]));
      check_val("store_byte1", 32'(env_rd(lsb_r.addr + 32'd1)), 32'(lsb_r.anc[15:8]));
    end
  endtask

  task automatic release_req(input bit who);
    if (who == 1'b0) begin ic_pend = 1'b0; ic_gap = $urandom_range(0, 3); end
    else begin lsb_pend = 1'b0; lsb_gap = $urandom_range(0, 3); end
  endtask

  // Advance the reference model across the clock edge using this cycle's inputs.
  task automatic model_advance();
    if (rst) begin
      m_act = 1'b0; m_last = 1'b1; m_ic_h = 32'h0; m_lsb_h = 32'h0;
      release_req(1'b0);
      release_req(1'b1);
    end else if (m_act) begin
      if (!m_we) begin
        if (flush && (m_t <= m_n + 1)) begin m_act = 1'b0; release_req(m_who); end
        else if (m_t == m_n + 2) begin m_act = 1'b0; release_req(m_who); end
        else m_t++;
      end else if (m_wdone) begin
        m_act = 1'b0; release_req(1'b1);
      end else if (!stall_now) begin
        ref_ram[m_addr + 32'(m_w)] = m_wdata[8*m_w +: 8];
        m_w++;
        if (m_w == m_n) m_wdone = 1'b1;
      end
    end else if (!flush && (bus.ic_req || bus.lsb_req)) begin
      if (bus.ic_req && bus.lsb_req) m_who = !m_last;
      else m_who = bus.lsb_req;
      m_last = m_who;
      m_act = 1'b1; m_t = 1; m_w = 0; m_wdone = 1'b0;
      if (m_who == 1'b0) begin
        m_addr = ic_r.addr; m_n = 4; m_we = 1'b0; m_sgn = 1'b0; m_wdata = 32'h0;
      end else begin
        m_addr = lsb_r.addr; m_we = lsb_r.we; m_sgn = lsb_r.sgn; m_wdata = lsb_r.wdata;
        m_n = (lsb_r.size == 2'b00) ? 1 : (lsb_r.size == 2'b01) ? 2 : 4;
      end
      m_rdata = 32'h0;
      for (int i = 0; i < m_n; i++) m_rdata[8*i +: 8] = ref_rd(m_addr + 32'(i));
      if (m_n == 1 && m_sgn && m_rdata[7])  m_rdata[31:8]  = 24'hFF_FFFF;
      if (m_n == 2 && m_sgn && m_rdata[15]) m_rdata[31:16] = 16'hFFFF;
    end
  endtask

  // Pick requests, flush and reset for the next cycle.
  task automatic choose_stim();
    if (!ic_pend) begin if (ic_gap > 0) ic_gap--; else new_ic(); end
    if (!lsb_pend) begin if (lsb_gap > 0) lsb_gap--; else new_lsb(); end
    next_rst   = (cyc == 1500);
    next_flush = 1'b0;
    if (!next_rst) begin
      if (fl_ic_once && cyc > 50 && m_act && !m_we && m_who == 1'b0 && m_t == 3) begin
        next_flush = 1'b1; fl_ic_once = 1'b0;
      end else if (fl_st_once && m_act && m_we && m_n == 4 && m_w == 1 && !m_wdone) begin
        next_flush = 1'b1; fl_st_once = 1'b0;
      end else if (cyc > 60) begin
        next_flush = ($urandom_range(0, 49) == 0);
      end else begin
        next_flush = 1'b0;
      end
    end
  endtask

  initial begin
    env_ram[32'h100] = 8'h13; env_ram[32'h101] = 8'h05; env_ram[32'h102] = 8'h00; env_ram[32'h103] = 8'h00;
    env_ram[32'h2000] = 8'h80;
    ref_ram = env_ram;
    ic_q.push_back('{we: 1'b0, size: 2'b10, sgn: 1'b0, addr: 32'h100, wdata: 32'h0, anc_v: 1'b1, anc: 32'h0000_0513});
    lsb_q.push_back('{we: 1'b0, size: 2'b00, sgn: 1'b1, addr: 32'h2000, wdata: 32'h0, anc_v: 1'b1, anc: 32'hFFFF_FF80});
    lsb_q.push_back('{we: 1'b0, size: 2'b00, sgn: 1'b0, addr: 32'h2000, wdata: 32'h0, anc_v: 1'b1, anc: 32'h0000_0080});
    lsb_q.push_back('{we: 1'b1, size: 2'b01, sgn: 1'b0, addr: 32'h10, wdata: 32'hABCD_1234, anc_v: 1'b1, anc: 32'h0000_1234});
    lsb_q.push_back('{we: 1'b1, size: 2'b10, sgn: 1'b0, addr: 32'h40, wdata: 32'hDEAD_BEEF, anc_v: 1'b0, anc: 32'h0});
    lsb_q.push_back('{we: 1'b0, size: 2'b10, sgn: 1'b0, addr: 32'hFFFF_FFFE, wdata: 32'h0, anc_v: 1'b0, anc: 32'h0});
    fl_ic_once = 1'b1; fl_st_once = 1'b1;
    m_act = 1'b0; m_last = 1'b1; m_ic_h = 32'h0; m_lsb_h = 32'h0; stall_now = 1'b0;
    ic_pend = 1'b0; lsb_pend = 1'b0; ic_gap = 0; lsb_gap = 0;
    ic_r = '{we: 1'b0, size: 2'b10, sgn: 1'b0, addr: 32'h0, wdata: 32'h0, anc_v: 1'b0, anc: 32'h0};
    lsb_r = ic_r;
    next_rst = 1'b1; next_flush = 1'b0; next_din = 8'h00;
    drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_a", bus.mem_a, 32'h0);
    check_val("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    check_val("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_ic_done", 32'(bus.ic_done), 32'h0);
    check_val("rst_lsb_done", 32'(bus.lsb_done), 32'h0);
    check_val("rst_ic_data", bus.ic_data, 32'h0);
    check_val("rst_lsb_rdata", bus.lsb_rdata, 32'h0);
    new_ic();
    new_lsb();
    next_rst = 1'b0;
    @(posedge clk); #1;
    drive_inputs();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      model_check();
      if (bus.mem_wr) env_ram[bus.mem_a] = bus.mem_dout;
      next_din = env_rd(bus.mem_a);
      model_advance();
      choose_stim();
      @(posedge clk); #1;
      drive_inputs();
      cyc++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
